// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve path.
// Queue entry layout, delay-slot offset and the resolve FSM states.
package bp_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_entry_t;

  localparam logic [31:0] DELAY_SLOT_OFF = 32'd8;

  typedef enum logic {
    RUN,
    SQUASH
  } bp_state_t;

  // A target mismatch only matters when both prediction and outcome are taken
  function automatic logic isMispredict(input bp_entry_t head,
                                        input logic        resTaken,
                                        input logic [31:0] resTarget);
    return (head.taken != resTaken) ||
           (head.taken && resTaken && (head.target != resTarget));
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/resolve-side bundle of the branch resolve unit.
// master drives predictions and resolutions; slave is the resolve unit.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);

  logic             push_valid;
  logic [31:0]      push_pc;
  logic             push_taken;
  logic [31:0]      push_target;
  logic             push_ready;

  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             flush;

  logic             pmis;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic             upd_pred;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;
  logic             err;

  modport master (
    output push_valid, push_pc, push_taken, push_target,
    output res_valid, res_taken, res_target, flush,
    input  push_ready, pmis, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_pred,
    input  stat_branches, stat_mispredicts, err
  );

  modport slave (
    input  push_valid, push_pc, push_taken, push_target,
    input  res_valid, res_taken, res_target, flush,
    output push_ready, pmis, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_pred,
    output stat_branches, stat_mispredicts, err
  );

endinterface

// File: rtl/bp_queue.sv
// In-order circular buffer of in-flight predictions.
// Head is read combinationally so it can be compared in the resolve cycle.
module bp_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pushEn,
  input  bp_entry_t pushData,
  input  logic      popEn,
  input  logic      clear,
  output bp_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  bp_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign doPush = pushEn && !full && !clear;
  assign doPop  = popEn && !empty && !clear;
  assign head   = mem[rdPtr];

  // Storage carries no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= rdPtr;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued predictions against resolved outcomes, redirects fetch on a
// mispredict, squashes wrong-path entries and emits predictor training packets.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  bp_state_t        state;
  bp_entry_t        head;
  bp_entry_t        pushEntry;
  logic             full;
  logic             empty;
  logic             resolveOk;
  logic             mispredict;
  logic             pushOk;
  logic             clearQ;
  logic             errSet;
  logic [31:0]      redirectPc;
  logic [CNT_W-1:0] statBranches;
  logic [CNT_W-1:0] statMispredicts;
  logic             errSticky;

  // Ready depends only on registered state, never on this cycle's resolve
  assign bus.push_ready = (state == RUN) && !full;

  assign resolveOk  = bus.res_valid && !empty && (state == RUN) && !bus.flush;
  assign mispredict = resolveOk && isMispredict(head, bus.res_taken, bus.res_target);
  assign pushOk     = bus.push_valid && bus.push_ready && !bus.flush && !mispredict;
  assign clearQ     = bus.flush || mispredict;
  assign errSet     = bus.res_valid && empty && (state == RUN);
  assign redirectPc = bus.res_taken ? bus.res_target : (head.pc + DELAY_SLOT_OFF);

  assign pushEntry.pc     = bus.push_pc;
  assign pushEntry.taken  = bus.push_taken;
  assign pushEntry.target = bus.push_target;

  bp_queue #(
    .DEPTH (DEPTH)
  ) queue (
    .clk      (clk),
    .rst      (rst),
    .pushEn   (pushOk),
    .pushData (pushEntry),
    .popEn    (resolveOk),
    .clear    (clearQ),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RUN;
      bus.pmis        <= 1'b0;
      bus.redirect_pc <= '0;
      bus.upd_valid   <= 1'b0;
      bus.upd_pc      <= '0;
      bus.upd_taken   <= 1'b0;
      bus.upd_pred    <= 1'b0;
      statBranches    <= '0;
      statMispredicts <= '0;
      errSticky       <= 1'b0;
    end else begin
      bus.pmis      <= mispredict;
      bus.upd_valid <= resolveOk;
      if (mispredict) begin
        bus.redirect_pc <= redirectPc;
      end
      if (resolveOk) begin
        bus.upd_pc    <= head.pc;
        bus.upd_taken <= bus.res_taken;
        bus.upd_pred  <= head.taken;
      end
      if (resolveOk && (statBranches != '1)) begin
        statBranches <= statBranches + CNT_W'(1);
      end
      if (mispredict && (statMispredicts != '1)) begin
        statMispredicts <= statMispredicts + CNT_W'(1);
      end
      if (errSet) begin
        errSticky <= 1'b1;
      end
      // Flush overrides everything; the squash bubble lasts exactly one cycle
      if (bus.flush) begin
        state <= RUN;
      end else if (mispredict) begin
        state <= SQUASH;
      end else if (state == SQUASH) begin
        state <= RUN;
      end
    end
  end

  assign bus.stat_branches    = statBranches;
  assign bus.stat_mispredicts = statMispredicts;
  assign bus.err              = errSticky;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected training packets are queued
// at stimulus time and checked by an independent monitor.
module tb_branch_resolve_unit;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        pred;
    logic        mis;
    logic [31:0] redir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(16)) bus ();

  branch_resolve_unit #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (bus.upd_valid) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL upd_unexpected: got upd_pc 0x%0h pmis %0d, required no update",
                   bus.upd_pc, bus.pmis);
        end else begin
          e = sb.pop_front();
          $display("upd pc=0x%0h taken=%0d pred=%0d pmis=%0d redirect=0x%0h",
                   bus.upd_pc, bus.upd_taken, bus.upd_pred, bus.pmis, bus.redirect_pc);
          chk("upd_pc", bus.upd_pc, e.pc);
          chk("upd_taken", 32'(bus.upd_taken), 32'(e.taken));
          chk("upd_pred", 32'(bus.upd_pred), 32'(e.pred));
          chk("pmis", 32'(bus.pmis), 32'(e.mis));
          if (e.mis) chk("redirect_pc", bus.redirect_pc, e.redir);
        end
      end else if (bus.pmis) begin
        nChecks++;
        nFails++;
        $display("FAIL pmis_without_upd: got pmis 1, required 0");
      end
    end
  end

  task automatic idle();
    bus.push_valid  = 1'b0;
    bus.push_pc     = '0;
    bus.push_taken  = 1'b0;
    bus.push_target = '0;
    bus.res_valid   = 1'b0;
    bus.res_taken   = 1'b0;
    bus.res_target  = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic setPush(input logic [31:0] pc, input logic taken, input logic [31:0] target);
    bus.push_valid  = 1'b1;
    bus.push_pc     = pc;
    bus.push_taken  = taken;
    bus.push_target = target;
  endtask

  task automatic setRes(input logic taken, input logic [31:0] target);
    bus.res_valid  = 1'b1;
    bus.res_taken  = taken;
    bus.res_target = target;
  endtask

  task automatic expectUpd(input logic [31:0] pc, input logic taken, input logic pred,
                           input logic mis, input logic [31:0] redir);
    exp_t e;
    e.pc = pc; e.taken = taken; e.pred = pred; e.mis = mis; e.redir = redir;
    sb.push_back(e);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_push_ready"}, 32'(bus.push_ready), 32'd1);
    chk({tag, "_pmis"}, 32'(bus.pmis), 32'd0);
    chk({tag, "_redirect_pc"}, bus.redirect_pc, 32'd0);
    chk({tag, "_upd_valid"}, 32'(bus.upd_valid), 32'd0);
    chk({tag, "_upd_pc"}, bus.upd_pc, 32'd0);
    chk({tag, "_upd_taken"}, 32'(bus.upd_taken), 32'd0);
    chk({tag, "_upd_pred"}, 32'(bus.upd_pred), 32'd0);
    chk({tag, "_stat_branches"}, 32'(bus.stat_branches), 32'd0);
    chk({tag, "_stat_mispredicts"}, 32'(bus.stat_mispredicts), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    chkResetOutputs("reset");
    rst = 1'b1;
    step();

    // Correct not-taken prediction
    setPush(32'h100, 1'b0, 32'h0);
    step();
    setRes(1'b0, 32'h0);
    expectUpd(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("t1_stat_branches", 32'(bus.stat_branches), 32'd1);
    chk("t1_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd0);

    // Predicted taken, actually not taken: fall through past the delay slot
    setPush(32'h200, 1'b1, 32'h400);
    step();
    setRes(1'b0, 32'h0);
    expectUpd(32'h200, 1'b0, 1'b1, 1'b1, 32'h208);
    step();
    chk("t2_squash_push_ready", 32'(bus.push_ready), 32'd0);
    chk("t2_stat_branches", 32'(bus.stat_branches), 32'd2);
    chk("t2_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd1);
    step();
    chk("t2_run_push_ready", 32'(bus.push_ready), 32'd1);

    // Taken both ways but target differs
    setPush(32'h200, 1'b1, 32'h400);
    step();
    setRes(1'b1, 32'h480);
    expectUpd(32'h200, 1'b1, 1'b1, 1'b1, 32'h480);
    step();
    chk("t3_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd2);
    step();

    // Fill the queue, refuse at full, then keep it busy across pointer wrap
    for (int i = 0; i < 4; i++) begin
      setPush(32'h300 + 32'(i * 16), 1'b0, 32'h0);
      step();
      chk("t4_fill_push_ready", 32'(bus.push_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    setPush(32'h340, 1'b0, 32'h0);
    setRes(1'b0, 32'h0);
    expectUpd(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("t4_after_refused_push_ready", 32'(bus.push_ready), 32'd1);
    setPush(32'h340, 1'b0, 32'h0);
    setRes(1'b0, 32'h0);
    expectUpd(32'h310, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("t4_push_pop_push_ready", 32'(bus.push_ready), 32'd1);
    setPush(32'h350, 1'b0, 32'h0);
    step();
    chk("t4_refill_push_ready", 32'(bus.push_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      setRes(1'b0, 32'h0);
      expectUpd(32'h320 + 32'(i * 16), 1'b0, 1'b0, 1'b0, 32'h0);
      step();
    end
    chk("t4_stat_branches", 32'(bus.stat_branches), 32'd9);
    chk("t4_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd2);

    // Oldest of three mispredicts: younger entries vanish
    for (int i = 0; i < 3; i++) begin
      setPush(32'h500 + 32'(i * 16), 1'b0, 32'h0);
      step();
    end
    setRes(1'b1, 32'h600);
    expectUpd(32'h500, 1'b1, 1'b0, 1'b1, 32'h600);
    step();
    step();
    chk("t5_err_before", 32'(bus.err), 32'd0);
    setRes(1'b0, 32'h0);
    step();
    chk("t5_err_set", 32'(bus.err), 32'd1);
    chk("t5_stat_branches", 32'(bus.stat_branches), 32'd10);
    chk("t5_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd3);

    // Flush wins over a would-be mispredict resolve
    for (int i = 0; i < 3; i++) begin
      setPush(32'h700 + 32'(i * 16), 1'b0, 32'h0);
      step();
    end
    bus.flush = 1'b1;
    setRes(1'b1, 32'h999);
    step();
    chk("t6_pmis", 32'(bus.pmis), 32'd0);
    chk("t6_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("t6_push_ready", 32'(bus.push_ready), 32'd1);
    chk("t6_stat_branches", 32'(bus.stat_branches), 32'd10);
    chk("t6_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd3);
    setRes(1'b0, 32'h0);
    step();
    chk("t6_empty_stat_branches", 32'(bus.stat_branches), 32'd10);
    chk("t6_err_sticky", 32'(bus.err), 32'd1);
    setPush(32'h800, 1'b0, 32'h0);
    step();
    setRes(1'b0, 32'h0);
    expectUpd(32'h800, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("t6_stat_branches_after", 32'(bus.stat_branches), 32'd11);

    // Asynchronous reset with live outputs and entries still queued
    setPush(32'h900, 1'b0, 32'h0);
    step();
    setPush(32'h910, 1'b0, 32'h0);
    step();
    setRes(1'b1, 32'hA00);
    expectUpd(32'h900, 1'b1, 1'b0, 1'b1, 32'hA00);
    step();
    chk("t7_stat_branches", 32'(bus.stat_branches), 32'd12);
    chk("t7_stat_mispredicts", 32'(bus.stat_mispredicts), 32'd4);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chkResetOutputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    setRes(1'b0, 32'h0);
    step();
    chk("t7_err_after_reset", 32'(bus.err), 32'd1);
    chk("t7_stat_branches_after_reset", 32'(bus.stat_branches), 32'd0);

    step();
    step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
